// File: rtl/sigmoid_backward_4slice_pkg.sv
// Shared Q16.16 constants for the piecewise-linear sigmoid (forward and backward blocks).
// Breakpoints, slopes and the segment-to-slope lookup live here so all sigmoid blocks agree.
package sigmoid_pkg;

    localparam int FRAC_W = 16;
    localparam int DATA_W = 32;

    typedef logic signed [DATA_W-1:0] q16_t;

    localparam q16_t X1 = 32'shFFFC_0000;
    localparam q16_t X2 = 32'shFFFF_0000;
    localparam q16_t X3 = 32'sh0001_0000;
    localparam q16_t X4 = 32'sh0004_0000;

    localparam q16_t M1 = 32'sh0000_0000;
    localparam q16_t M2 = 32'sh0000_1567;
    localparam q16_t M3 = 32'sh0000_3B2A;
    localparam q16_t M4 = 32'sh0000_1567;
    localparam q16_t M5 = 32'sh0000_0000;

    typedef enum logic [2:0] {
        SEG_1 = 3'd0,
        SEG_2 = 3'd1,
        SEG_3 = 3'd2,
        SEG_4 = 3'd3,
        SEG_5 = 3'd4
    } seg_e;

    function automatic q16_t seg_slope(input seg_e seg);
        q16_t m;
        case (seg)
            SEG_1:   m = M1;
            SEG_2:   m = M2;
            SEG_3:   m = M3;
            SEG_4:   m = M4;
            SEG_5:   m = M5;
            default: m = 32'sh0000_0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sigmoid_backward_4slice_if.sv
// Valid/ready stream bundle for the sigmoid backward block: (x, grad) in, dL/dx out.
interface sigmoid_backward_4slice_if;
    import sigmoid_pkg::*;

    logic in_valid;
    logic in_ready;
    q16_t x_in;
    q16_t grad_in;
    logic out_valid;
    logic out_ready;
    q16_t grad_out;

    modport master (
        output in_valid, x_in, grad_in, out_ready,
        input  in_ready, out_valid, grad_out
    );

    modport slave (
        input  in_valid, x_in, grad_in, out_ready,
        output in_ready, out_valid, grad_out
    );

endinterface

// File: rtl/sigmoid_backward_4slice_slope_select.sv
// Combinational segment decode: maps a Q16.16 x onto the slope of its sigmoid segment.
// A value sitting exactly on a breakpoint belongs to the segment above it.
module sigmoid_slope_select
    import sigmoid_pkg::*;
(
    input  q16_t x,
    output q16_t m
);

    seg_e seg_s;

    // Signed range decode; strict less-than pushes breakpoint values upward.
    always_comb begin
        seg_s = SEG_5;
        if (x < X1) begin
            seg_s = SEG_1;
        end else if (x < X2) begin
            seg_s = SEG_2;
        end else if (x < X3) begin
            seg_s = SEG_3;
        end else if (x < X4) begin
            seg_s = SEG_4;
        end else begin
            seg_s = SEG_5;
        end
    end

    assign m = seg_slope(seg_s);

endmodule

// File: rtl/sigmoid_backward_4slice.sv
// Sigmoid backward pass, 3-stage pipeline: grad_out = (grad_in * m_k) >>> 16.
// Optional macro SIGMOID_BWD_ROUND_EN: round half up before the shift instead of truncating.
module sigmoid_backward_4slice
    import sigmoid_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    sigmoid_backward_4slice_if.slave   bus
);

`ifdef SIGMOID_BWD_ROUND_EN
    localparam logic signed [2*DATA_W-1:0] ROUND_ADD = 64'sh0000_0000_0000_8000;
`else
    localparam logic signed [2*DATA_W-1:0] ROUND_ADD = 64'sh0000_0000_0000_0000;
`endif

    logic                       en_s;
    q16_t                       m_sel_s;
    logic                       v1_r;
    logic                       v2_r;
    logic                       v3_r;
    q16_t                       m1_r;
    q16_t                       g1_r;
    logic signed [2*DATA_W-1:0] prod_r;
    q16_t                       grad_out_r;

    // Whole pipe advances together; it only freezes when a result is waiting downstream.
    assign en_s          = ~v3_r | bus.out_ready;
    assign bus.in_ready  = en_s;
    assign bus.out_valid = v3_r;
    assign bus.grad_out  = grad_out_r;

    sigmoid_slope_select u_slope_select (
        .x (bus.x_in),
        .m (m_sel_s)
    );

    // S1: capture the selected slope and the upstream gradient.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r <= 1'b0;
            m1_r <= 32'sh0000_0000;
            g1_r <= 32'sh0000_0000;
        end else if (en_s) begin
            v1_r <= bus.in_valid;
            m1_r <= m_sel_s;
            g1_r <= bus.grad_in;
        end else begin
            v1_r <= v1_r;
        end
    end

    // S2: full-precision signed product.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r   <= 1'b0;
            prod_r <= 64'sh0000_0000_0000_0000;
        end else if (en_s) begin
            v2_r   <= v1_r;
            prod_r <= (2*DATA_W)'(g1_r) * (2*DATA_W)'(m1_r);
        end else begin
            v2_r   <= v2_r;
        end
    end

    // S3: rescale to Q16.16; |m_k| < 1 so the low word never overflows.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_r       <= 1'b0;
            grad_out_r <= 32'sh0000_0000;
        end else if (en_s) begin
            v3_r       <= v2_r;
            grad_out_r <= DATA_W'((prod_r + ROUND_ADD) >>> FRAC_W);
        end else begin
            v3_r       <= v3_r;
        end
    end

endmodule

// File: tb/tb_sigmoid_backward_4slice.sv
// Scoreboard bench for sigmoid_backward_4slice: directed cases, backpressure, mid-run reset, random traffic.
module tb_sigmoid_backward_4slice;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sigmoid_backward_4slice_if bus ();

    sigmoid_backward_4slice dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          stamp;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    bit          tag_lat = 1'b0;
    bit          stall_prev = 1'b0;
    logic [31:0] prev_data  = 32'h0;
    bit          rdone      = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: pick slope from the piecewise-linear sigmoid, multiply in 64-bit, rescale.
    function automatic logic [31:0] ref_grad(input logic [31:0] x, input logic [31:0] g);
        int     xi;
        longint slope;
        longint p;
        xi = $signed(x);
        if (xi < -262144)     slope = 0;
        else if (xi < -65536) slope = 5479;
        else if (xi < 65536)  slope = 15146;
        else if (xi < 262144) slope = 5479;
        else                  slope = 0;
        p = longint'($signed(g)) * slope;
`ifdef SIGMOID_BWD_ROUND_EN
        p = p + 32768;
`endif
        p = p >>> 16;
        return p[31:0];
    endfunction

    // Monitor: samples between edges, records accepts and checks retires.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (stall_prev) begin
                check("stall_valid_hold", bus.out_valid, 1'b1);
                check("stall_data_hold", bus.grad_out, prev_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_output", bus.grad_out, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("grad_out", bus.grad_out, e.data);
                    if (e.lat) check("latency", cyc - e.stamp, 32'd3);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back('{data: ref_grad(bus.x_in, bus.grad_in), stamp: cyc, lat: tag_lat});
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_data  = bus.grad_out;
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] g, input bit lat);
        bit acc;
        acc         = 1'b0;
        bus.in_valid = 1'b1;
        bus.x_in     = x;
        bus.grad_in  = g;
        tag_lat      = lat;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            acc = bus.in_ready && !rst;
            @(posedge clk);
            #2;
            if (acc) break;
        end
        check("accept_in_time", acc, 1'b1);
        bus.in_valid = 1'b0;
        tag_lat      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        #2;
        check("drain_empty", sb.size(), 32'd0);
    endtask

    function automatic logic [31:0] rand_x();
        logic [31:0] bp[4];
        int          sel;
        bp[0] = 32'hFFFC_0000;
        bp[1] = 32'hFFFF_0000;
        bp[2] = 32'h0001_0000;
        bp[3] = 32'h0004_0000;
        sel = $urandom_range(0, 3);
        case (sel)
            0:       return bp[$urandom_range(0, 3)] + 32'($urandom_range(0, 2)) - 32'd1;
            1:       return $urandom;
            default: return 32'($urandom_range(0, 786432)) - 32'd393216;
        endcase
    endfunction

    initial begin
        bus.in_valid  = 1'b1;
        bus.x_in      = 32'h0;
        bus.grad_in   = 32'h0001_0000;
        bus.out_ready = 1'b1;
        rst           = 1'b1;

        // Reset held for two cycles while upstream claims valid data
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_grad_out", bus.grad_out, 32'h0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b1);
        idle(1);

        // Directed single transactions
        send(32'h0000_0000, 32'h0001_0000, 1'b1);
        idle(4);
        send(32'hFFFC_0000, 32'h0002_0000, 1'b0);
        send(32'h0005_0000, $urandom, 1'b0);
        send(32'h0000_0000, 32'hFFFF_0000, 1'b0);
        send(32'h0000_0000, 32'h0000_0003, 1'b0);
        wait_drain();
        idle(1);

        // Back-to-back stream with a 4-cycle downstream stall
        fork
            begin
                for (int i = 0; i < 6; i++) send(rand_x(), $urandom, 1'b0);
            end
            begin
                idle(4);
                bus.out_ready = 1'b0;
                idle(4);
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();
        idle(1);

        // Reset with two results still inside the pipe
        send(32'h0000_0000, 32'h0001_0000, 1'b0);
        send(32'h0002_0000, 32'h0003_0000, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(5);
        send(32'hFFFE_0000, 32'h0004_0000, 1'b1);
        wait_drain();
        idle(1);

        // Random traffic with random gaps and random backpressure
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 4) == 0) idle(1);
                    send(rand_x(), $urandom, 1'b0);
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #2;
                    if (!rdone) bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_drain();
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sigmoid_backward_4slice.md
SIGMOID_BACKWARD_4SLICE -- requirements
Module: sigmoid_backward_4slice

Interface
REQ-001 The block SHALL have port `clk`: input, 1 bit, single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port `rst`: input, 1 bit, synchronous, active-high reset.
REQ-003 The block SHALL have port `in_valid`: input, 1 bit, upstream holds a valid (x, grad) pair.
REQ-004 The block SHALL have port `in_ready`: output, 1 bit, block accepts the pair this cycle.
REQ-005 The block SHALL have port `x_in`: input, 32 bits, signed Q16.16 forward-pass pre-activation value.
REQ-006 The block SHALL have port `grad_in`: input, 32 bits, signed Q16.16 upstream gradient dL/dy.
REQ-007 The block SHALL have port `out_valid`: output, 1 bit, `grad_out` is valid.
REQ-008 The block SHALL have port `out_ready`: input, 1 bit, downstream accepts `grad_out`.
REQ-009 The block SHALL have port `grad_out`: output, 32 bits, signed Q16.16 dL/dx.

Function
REQ-010 The block SHALL compute grad_out = grad_in * m_k. m_k is the slope of the 5-segment piecewise-linear sigmoid, selected by x_in.
REQ-011 The block SHALL use breakpoints x1..x4 = -4.0, -1.0, +1.0, +4.0 (0xFFFC0000, 0xFFFF0000, 0x00010000, 0x00040000), with signed comparison.
REQ-012 The block SHALL use these slopes:
- m1 = 0 for x<-4
- m2 = 0x00001567 for -4≤x<-1
- m3 = 0x00003B2A for -1≤x<1
- m4 = 0x00001567 for 1≤x<4
- m5 = 0 for x≥4
REQ-013 An x_in exactly equal to a breakpoint SHALL select the upper segment.
REQ-014 The pipeline SHALL have 3 stages:
- S1: segment select, register m_k and grad_in
- S2: signed 32x32 multiply, register the 64-bit product
- S3: arithmetic shift right by 16, take the low 32 bits, register into `grad_out`
REQ-015 Latency SHALL be exactly 3 cycles from an accepted input to `out_valid` when there is no stall.
REQ-016 The global advance enable SHALL be en = ~out_valid | out_ready; in_ready SHALL equal en.
REQ-017 When en=0, all stage registers and valid bits SHALL hold, and `grad_out` SHALL be stable while out_valid=1.
REQ-018 A transfer SHALL occur only when valid and ready are both 1 in the same cycle, on each side.
REQ-019 Bubbles (in_valid=0 while en=1) SHALL propagate as valid=0 through the stages.
REQ-020 Throughput SHALL be 1 result per cycle while out_ready stays 1.
REQ-021 An input accept and an output retire in the same cycle SHALL both take effect.
REQ-022 Because |m_k|<1, the product SHALL NOT overflow 32 bits after the shift; no saturation logic.

Reset
REQ-023 While rst=1 at a clock edge, all stage valid bits, out_valid, grad_out and the internal data registers SHALL clear to 0.
REQ-024 Reset mid-operation SHALL discard all in-flight results with no partial output.
REQ-025 in_ready SHALL be 1 in the cycle after reset, since out_valid=0.

Configuration
REQ-026 With SIGMOID_BWD_ROUND_EN defined, S3 SHALL add 0x00008000 to the 64-bit product before the arithmetic shift (round half up).
REQ-027 Without SIGMOID_BWD_ROUND_EN, S3 SHALL truncate toward negative infinity (plain arithmetic shift).
REQ-028 Latency and handshake SHALL be identical in both configurations.

Structure
REQ-029 Package `sigmoid_pkg` SHALL hold:
- the Q16.16 fraction-width constant (16) and data width (32)
- breakpoint constants X1..X4
- slope constants M1..M5

Forward sigmoid blocks SHALL share these same constants.
REQ-030 The block SHALL contain one combinational sub-module, `sigmoid_slope_select` (x -> m_k), instantiated in S1.

Verification
REQ-031 Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, grad_out=0; in_ready=1 after release.
REQ-032 The bench SHALL cover these single-transaction cases:

| x_in | grad_in | Required grad_out |
|---|---|---|
| 0x00000000 | 0x00010000 | 0x00003B2A, exactly 3 cycles later |
| 0xFFFC0000 (boundary -4) | 0x00020000 | 0x00002ACE (segment 2) |
| 0x00050000 | any | 0x00000000 |
| 0x00000000 | 0xFFFF0000 | 0xFFFFC4D6 |

REQ-033 Rounding: x=0, grad_in=0x00000003 -> grad_out=0x00000001 with SIGMOID_BWD_ROUND_EN and 0x00000000 without it.
REQ-034 Backpressure: stream 6 back-to-back inputs and hold out_ready=0 for 4 cycles mid-stream. Required response:
- in_ready=0 while out_valid=1
- grad_out stable during the stall
- all 6 results arrive in order with no loss or duplication
REQ-035 Mid-operation reset: assert rst with 2 results in flight -> both are discarded and the next accepted input yields its correct result 3 cycles later.
